// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised multi-read-port register file.
package regfile_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam int INIT_ZERO  = 0;
  localparam int INIT_INDEX = 1;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Init sequencer: walks every register after reset or on request, writing the fill value;
// ready is held low until the last register has been filled.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int DEPTH     = 32,
  parameter  int INIT_MODE = INIT_INDEX,
  localparam int AW        = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_req,
  output logic             ready,
  output logic             fill_we,
  output logic [AW-1:0]    fill_addr,
  output logic [WIDTH-1:0] fill_data
);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_we = 1'b0;
    ready   = 1'b0;
    case (state_q)
      ST_INIT: begin
        fill_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        ready = 1'b1;
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign fill_addr = cnt_q;
  assign fill_data = (INIT_MODE == INIT_INDEX) ? WIDTH'(cnt_q) : '0;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD combinational read ports, one write port, optional
// hardwired-zero register and hardware init. Define REGFILE_BYPASS_EN for write-first reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int DEPTH     = 32,
  parameter  int NUM_RD    = 2,
  parameter  int ZERO_REG  = 1,
  parameter  int INIT_MODE = INIT_INDEX,
  localparam int AW        = addr_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_req,
  output logic                    ready,
  output logic                    wr_drop,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [NUM_RD*AW-1:0]    raddr,
  output logic [NUM_RD*WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             fill_we;
  logic [AW-1:0]    fill_addr;
  logic [WIDTH-1:0] fill_data;
  logic             user_we;

  regfile_init_seq #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .INIT_MODE(INIT_MODE)
  ) u_init_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_req (init_req),
    .ready    (ready),
    .fill_we  (fill_we),
    .fill_addr(fill_addr),
    .fill_data(fill_data)
  );

  assign user_we = ready && we && !((ZERO_REG != 0) && (waddr == '0));

  // NOTE: the array has no reset; the init sequencer defines its contents before ready rises.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[fill_addr] <= fill_data;
    end else if (user_we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_drop <= 1'b0;
    end else if (we && !ready) begin
      wr_drop <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] val;

    assign ra = raddr[p*AW +: AW];

    // Zero-register and not-ready gating come last so they override the bypass.
    always_comb begin
      val = mem[ra];
`ifdef REGFILE_BYPASS_EN
      if (we && (waddr == ra)) val = wdata;
`endif
      if (!ready || ((ZERO_REG != 0) && (ra == '0))) val = '0;
    end

    assign rdata[p*WIDTH +: WIDTH] = val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 32x32/2-port instance and a DEPTH=8, NUM_RD=3 instance.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  logic        rst_n_a, init_req_a, we_a, ready_a, wr_drop_a;
  logic [4:0]  waddr_a;
  logic [31:0] wdata_a;
  logic [9:0]  raddr_a;
  logic [63:0] rdata_a;

  logic        rst_n_b, init_req_b, we_b, ready_b, wr_drop_b;
  logic [2:0]  waddr_b;
  logic [31:0] wdata_b;
  logic [8:0]  raddr_b;
  logic [95:0] rdata_b;

  regfile_mp #(
    .WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .INIT_MODE(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .init_req(init_req_a), .ready(ready_a),
    .wr_drop(wr_drop_a), .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
    .raddr(raddr_a), .rdata(rdata_a)
  );

  regfile_mp #(
    .WIDTH(32), .DEPTH(8), .NUM_RD(3), .ZERO_REG(1), .INIT_MODE(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .init_req(init_req_b), .ready(ready_b),
    .wr_drop(wr_drop_b), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
    .raddr(raddr_b), .rdata(rdata_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n_a = 1'b0; init_req_a = 1'b0; we_a = 1'b0; waddr_a = '0; wdata_a = '0; raddr_a = '0;
    rst_n_b = 1'b0; init_req_b = 1'b0; we_b = 1'b0; waddr_b = '0; wdata_b = '0; raddr_b = '0;
    tick();
    tick();
    check("a_rst_ready", ready_a, 1'b0);
    check("a_rst_wr_drop", wr_drop_a, 1'b0);
    check("a_rst_rdata", rdata_a, 64'h0);

    // Reset release: ready must rise on exactly the 32nd posedge.
    rst_n_a = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 1 || i == 31) check("a_init_busy", ready_a, 1'b0);
    end
    check("a_init_done", ready_a, 1'b1);

    raddr_a = {5'd0, 5'd5};
    #1;
    check("a_rd_r5", rdata_a[31:0], 32'h5);
    check("a_rd_r0", rdata_a[63:32], 32'h0);

    we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'hDEADBEEF; raddr_a = {5'd7, 5'd7};
    tick();
    we_a = 1'b0;
    #1;
    check("a_r7_p0", rdata_a[31:0], 32'hDEADBEEF);
    check("a_r7_p1", rdata_a[63:32], 32'hDEADBEEF);

    we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hFFFFFFFF; raddr_a = {5'd0, 5'd0};
    #1;
    check("a_r0_same_cycle", rdata_a[31:0], 32'h0);
    tick();
    we_a = 1'b0;
    #1;
    check("a_r0_after_p0", rdata_a[31:0], 32'h0);
    check("a_r0_after_p1", rdata_a[63:32], 32'h0);

    we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h1234; raddr_a = {5'd7, 5'd9};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("a_r9_same_cycle", rdata_a[31:0], 32'h1234);
`else
    check("a_r9_same_cycle", rdata_a[31:0], 32'h9);
`endif
    check("a_r7_unaffected", rdata_a[63:32], 32'hDEADBEEF);
    tick();
    we_a = 1'b0;
    #1;
    check("a_r9_after", rdata_a[31:0], 32'h1234);
    check("a_wr_drop_clean", wr_drop_a, 1'b0);

    // Re-init; a write and an init_req land mid-sequence and must both be ignored.
    init_req_a = 1'b1;
    tick();
    init_req_a = 1'b0;
    #1;
    check("a_reinit_ready_low", ready_a, 1'b0);
    check("a_reinit_rdata_gated", rdata_a, 64'h0);
    for (int i = 1; i <= 32; i++) begin
      we_a = (i == 3); waddr_a = 5'd3; wdata_a = 32'hAAAA5555; init_req_a = (i == 6);
      tick();
      if (i == 3) check("a_wr_drop_set", wr_drop_a, 1'b1);
      if (i == 31) check("a_reinit_busy", ready_a, 1'b0);
    end
    we_a = 1'b0; init_req_a = 1'b0;
    #1;
    check("a_reinit_done", ready_a, 1'b1);
    raddr_a = {5'd9, 5'd7};
    #1;
    check("a_refill_r7", rdata_a[31:0], 32'h7);
    check("a_refill_r9", rdata_a[63:32], 32'h9);
    raddr_a = {5'd31, 5'd3};
    #1;
    check("a_dropped_r3", rdata_a[31:0], 32'h3);
    check("a_refill_r31", rdata_a[63:32], 32'h1F);

    init_req_a = 1'b1;
    tick();
    init_req_a = 1'b0;
    for (int i = 1; i <= 32; i++) tick();
    check("a_second_init_done", ready_a, 1'b1);
    check("a_wr_drop_sticky", wr_drop_a, 1'b1);

    // Async reset clears wr_drop; a reset pulse at cnt=10 restarts the fill.
    rst_n_a = 1'b0;
    #1;
    check("a_rst_clears_drop", wr_drop_a, 1'b0);
    check("a_rst_clears_ready", ready_a, 1'b0);
    #2;
    rst_n_a = 1'b1;
    for (int i = 1; i <= 10; i++) tick();
    rst_n_a = 1'b0;
    #2;
    rst_n_a = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 31) check("a_restart_busy", ready_a, 1'b0);
    end
    check("a_restart_done", ready_a, 1'b1);
    raddr_a = {5'd31, 5'd10};
    #1;
    check("a_restart_rd", rdata_a, {32'h1F, 32'hA});

    // Second configuration: 8 registers, 3 read ports.
    rst_n_b = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) check("b_init_busy", ready_b, 1'b0);
    end
    check("b_init_done", ready_b, 1'b1);
    raddr_b = {3'd0, 3'd6, 3'd5};
    #1;
    check("b_rd_init", rdata_b, {32'h0, 32'h6, 32'h5});

    we_b = 1'b1; waddr_b = 3'd4; wdata_b = 32'hCAFEF00D;
    tick();
    we_b = 1'b0; raddr_b = {3'd4, 3'd4, 3'd4};
    #1;
    check("b_rd_shared", rdata_b, {3{32'hCAFEF00D}});

    init_req_b = 1'b1; we_b = 1'b1; waddr_b = 3'd2; wdata_b = 32'h77;
    tick();
    init_req_b = 1'b0; we_b = 1'b0;
    #1;
    check("b_req_write_no_drop", wr_drop_b, 1'b0);
    check("b_req_ready_low", ready_b, 1'b0);
    for (int i = 1; i <= 8; i++) tick();
    check("b_reinit_done", ready_b, 1'b1);
    raddr_b = {3'd2, 3'd4, 3'd7};
    #1;
    check("b_refill", rdata_b, {32'h2, 32'h4, 32'h7});

    init_req_b = 1'b1;
    tick();
    init_req_b = 1'b0;
    for (int i = 1; i <= 3; i++) tick();
    rst_n_b = 1'b0;
    #2;
    rst_n_b = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) check("b_restart_busy", ready_b, 1'b0);
    end
    check("b_restart_done", ready_b, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
